// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Latency: none (declarations and a combinational helper only).
// Backpressure: none.
package regfile_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int REG_AW    = $clog2(NREGS_DEF);

  // Widest write-port count the priority helper can resolve.
  localparam int WSEL_MAX  = 32;
  localparam int WSEL_W    = $clog2(WSEL_MAX);

  typedef logic [REG_AW-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xdata_t;
  typedef logic [WSEL_W-1:0]   wsel_t;

  // Winning write port for one register: highest-index set bit of the match vector.
  function automatic wsel_t wr_sel(input logic [WSEL_MAX-1:0] match);
    wsel_t sel;
    sel = '0;
    for (int j = 0; j < WSEL_MAX; j++) begin
      if (match[j]) sel = wsel_t'(j);
    end
    return sel;
  endfunction
endpackage

// File: rtl/regfile_if.sv
// Bundle of read, write, issue and flush signals of the register file.
// Latency: none (wiring only).
// Backpressure: none; every port is accepted every cycle.
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 4,
  parameter int NWR   = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                iss_valid;
  logic [AW-1:0]       iss_addr;
  logic                sb_flush;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_valid, iss_addr, sb_flush,
    input  rd_data, rd_busy
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_valid, iss_addr, sb_flush,
    output rd_data, rd_busy
  );
endinterface

// File: rtl/regfile_wr_arb.sv
// Per-register write arbiter: hit flag and highest-index winning port.
// Latency: combinational.
// Backpressure: none; losing ports are silently dropped for that register.
module regfile_wr_arb
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int NWR   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  output logic [NREGS-1:0]  hit,
  output wsel_t             sel [NREGS]
);
  for (genvar r = 0; r < NREGS; r++) begin : g_reg
    logic [WSEL_MAX-1:0] match;

    // Collect which enabled write ports target this register.
    always_comb begin
      match = '0;
      for (int j = 0; j < NWR; j++) begin
        match[j] = wr_en[j] && (wr_addr[j*AW +: AW] == AW'(r));
      end
    end

    // x0 is hard-wired, so it never reports a hit.
    assign hit[r] = (r != 0) && (|match);
    assign sel[r] = wr_sel(match);
  end
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with per-register busy scoreboard (REGFILE_WR_BYPASS_EN adds write-to-read forwarding).
// Latency: reads combinational; writes/busy visible the cycle after the edge (same cycle for data with bypass).
// Backpressure: none; all ports accepted every cycle, same-register write conflicts resolved by port index.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 4,
  parameter int NWR   = 2
) (
  input logic      clk,
  input logic      rst_n,
  regfile_if.slave rf
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]  regs [1:NREGS-1];
  logic [NREGS-1:1] busy;
  logic [NREGS-1:0] hit;
  wsel_t            sel [NREGS];
  logic [XLEN-1:0]  rf_view [NREGS];
  logic [NREGS-1:0] busy_view;

  regfile_wr_arb #(
    .NREGS (NREGS),
    .NWR   (NWR),
    .AW    (AW)
  ) u_arb (
    .wr_en   (rf.wr_en),
    .wr_addr (rf.wr_addr),
    .hit     (hit),
    .sel     (sel)
  );

  // Register array: each register takes the data of its winning write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 1; r < NREGS; r++) regs[r] <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (hit[r]) regs[r] <= rf.wr_data[int'(sel[r])*XLEN +: XLEN];
      end
    end
  end

  // Scoreboard: flush beats issue, issue beats a same-cycle writeback clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (rf.sb_flush)                                    busy[r] <= 1'b0;
        else if (rf.iss_valid && (rf.iss_addr == AW'(r)))   busy[r] <= 1'b1;
        else if (hit[r])                                    busy[r] <= 1'b0;
      end
    end
  end

  // Full-range views with x0 reading as zero/not-busy, so read muxes index directly.
  always_comb begin
    rf_view[0] = '0;
    for (int r = 1; r < NREGS; r++) rf_view[r] = regs[r];
  end
  assign busy_view = {busy, 1'b0};

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] addr;
    assign addr = rf.rd_addr[i*AW +: AW];
    assign rf.rd_busy[i] = busy_view[addr];
`ifdef REGFILE_WR_BYPASS_EN
    // hit[0] is never set, so x0 still reads zero.
    assign rf.rd_data[i*XLEN +: XLEN] =
      hit[addr] ? rf.wr_data[int'(sel[addr])*XLEN +: XLEN] : rf_view[addr];
`else
    assign rf.rd_data[i*XLEN +: XLEN] = rf_view[addr];
`endif
  end
endmodule
